// File: rtl/latency_probe.sv
// Latency probe: drives a 1..NUM_SAMPLES ramp into a pipeline under test, measures its
// latency and counts corrupted samples. Optional macro LATENCY_PROBE_FIRST_ERR_EN adds first-error capture.
module latency_probe #(
    parameter int WIDTH       = 8,
    parameter int MAX_LATENCY = 64,
    parameter int NUM_SAMPLES = 255,
    localparam int CNT_W      = $clog2(MAX_LATENCY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] probe_dout,
    input  logic [WIDTH-1:0] probe_din,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] latency,
    output logic [15:0]      mismatch_cnt
`ifdef LATENCY_PROBE_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0] first_err_idx,
    output logic             first_err_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE_ST      = 3'd0,
        FLUSH_ST     = 3'd1,
        SEND_WAIT_ST = 3'd2,
        CHECK_ST     = 3'd3,
        FINISH_ST    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LAT_C     = CNT_W'(MAX_LATENCY);
    localparam logic [WIDTH-1:0] LAST_SAMPLE_C = WIDTH'(NUM_SAMPLES);
    localparam logic [WIDTH-1:0] LAST_RX_C     = WIDTH'(NUM_SAMPLES - 1);
    localparam logic [WIDTH-1:0] ZERO_C        = WIDTH'(0);
    localparam logic [WIDTH-1:0] ONE_C         = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_C         = WIDTH'(2);
    localparam logic             SINGLE_C      = (NUM_SAMPLES == 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic [CNT_W-1:0]   lat_cnt_r;
    logic [WIDTH-1:0]   rx_idx_r;
    logic [WIDTH-1:0]   expected_r;
    logic [WIDTH-1:0]   probe_dout_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_s;
    logic               done_s;
    logic               timeout_r;
    logic [CNT_W-1:0]   latency_r;
    logic [15:0]        mismatch_cnt_r;
    logic               start_ok_s;
    logic               flush_last_s;
    logic               din_nz_s;
    logic               lat_hit_s;
    logic               rx_last_s;
    logic               mismatch_s;
    logic [WIDTH-1:0]   cmp_val_s;

    assign start_ok_s   = (state_r == IDLE_ST) && start;
    assign flush_last_s = (state_r == FLUSH_ST) && (flush_cnt_r == MAX_LAT_C);
    assign din_nz_s     = (probe_din != ZERO_C);
    assign lat_hit_s    = (lat_cnt_r == MAX_LAT_C);
    assign rx_last_s    = (state_r == CHECK_ST) && (rx_idx_r == LAST_RX_C);

    // Value the current response sample is compared against; 1 is the first ramp value.
    always_comb begin
        cmp_val_s  = expected_r;
        mismatch_s = 1'b0;
        if (state_r == SEND_WAIT_ST) begin
            cmp_val_s  = ONE_C;
            mismatch_s = din_nz_s && (probe_din != ONE_C);
        end else if (state_r == CHECK_ST) begin
            cmp_val_s  = expected_r;
            mismatch_s = (probe_din != expected_r);
        end else begin
            cmp_val_s  = expected_r;
            mismatch_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE_ST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE_ST: begin
                if (start) state_next_s = FLUSH_ST;
                else       state_next_s = IDLE_ST;
            end
            FLUSH_ST: begin
                if (flush_last_s) state_next_s = SEND_WAIT_ST;
                else              state_next_s = FLUSH_ST;
            end
            SEND_WAIT_ST: begin
                if (din_nz_s)       state_next_s = SINGLE_C ? FINISH_ST : CHECK_ST;
                else if (lat_hit_s) state_next_s = FINISH_ST;
                else                state_next_s = SEND_WAIT_ST;
            end
            CHECK_ST: begin
                if (rx_last_s) state_next_s = FINISH_ST;
                else           state_next_s = CHECK_ST;
            end
            FINISH_ST: state_next_s = IDLE_ST;
            default:   state_next_s = IDLE_ST;
        endcase
    end

    // Output decode from the next state so busy/done come straight out of flops.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_next_s)
            FLUSH_ST, SEND_WAIT_ST, CHECK_ST: busy_s = 1'b1;
            FINISH_ST:                        done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Status flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Transmit ramp: free-running once launched, so it does not depend on the receive side.
    always_ff @(posedge clk) begin
        if (reset) begin
            probe_dout_r <= ZERO_C;
        end else if (start_ok_s || ((state_r == FLUSH_ST) && !flush_last_s)) begin
            probe_dout_r <= ZERO_C;
        end else if (flush_last_s) begin
            probe_dout_r <= ONE_C;
        end else if (probe_dout_r != ZERO_C) begin
            probe_dout_r <= (probe_dout_r == LAST_SAMPLE_C) ? ZERO_C : probe_dout_r + ONE_C;
        end else begin
            probe_dout_r <= probe_dout_r;
        end
    end

    // Flush, latency and receive-index counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt_r <= '0;
            lat_cnt_r   <= '0;
            rx_idx_r    <= ZERO_C;
            expected_r  <= ZERO_C;
        end else begin
            if (start_ok_s)
                flush_cnt_r <= '0;
            else if ((state_r == FLUSH_ST) && !flush_last_s)
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            else
                flush_cnt_r <= flush_cnt_r;

            if (flush_last_s)
                lat_cnt_r <= '0;
            else if ((state_r == SEND_WAIT_ST) && !din_nz_s && !lat_hit_s)
                lat_cnt_r <= lat_cnt_r + CNT_W'(1);
            else
                lat_cnt_r <= lat_cnt_r;

            // Expected always advances in CHECK: a corrupted sample never resyncs the stream.
            if ((state_r == SEND_WAIT_ST) && din_nz_s) begin
                rx_idx_r   <= ONE_C;
                expected_r <= TWO_C;
            end else if (state_r == CHECK_ST) begin
                rx_idx_r   <= rx_idx_r + ONE_C;
                expected_r <= expected_r + ONE_C;
            end else begin
                rx_idx_r   <= rx_idx_r;
                expected_r <= expected_r;
            end
        end
    end

    // Measurement results; held in IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            timeout_r      <= 1'b0;
            latency_r      <= '0;
            mismatch_cnt_r <= 16'h0000;
        end else begin
            if ((state_r == SEND_WAIT_ST) && din_nz_s) begin
                timeout_r <= timeout_r;
                latency_r <= lat_cnt_r;
            end else if ((state_r == SEND_WAIT_ST) && lat_hit_s) begin
                timeout_r <= 1'b1;
                latency_r <= '1;
            end else begin
                timeout_r <= timeout_r;
                latency_r <= latency_r;
            end

            if (mismatch_s && (mismatch_cnt_r != 16'hFFFF))
                mismatch_cnt_r <= mismatch_cnt_r + 16'h0001;
            else
                mismatch_cnt_r <= mismatch_cnt_r;
        end
    end

`ifdef LATENCY_PROBE_FIRST_ERR_EN
    logic [WIDTH-1:0] first_err_idx_r;
    logic             first_err_valid_r;

    // First-error capture; the compare value equals the ramp index of the sample.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            first_err_idx_r   <= ZERO_C;
            first_err_valid_r <= 1'b0;
        end else if (mismatch_s && !first_err_valid_r) begin
            first_err_idx_r   <= cmp_val_s;
            first_err_valid_r <= 1'b1;
        end else begin
            first_err_idx_r   <= first_err_idx_r;
            first_err_valid_r <= first_err_valid_r;
        end
    end

    assign first_err_idx   = first_err_idx_r;
    assign first_err_valid = first_err_valid_r;
`else
    logic unused_cmp_s;
    assign unused_cmp_s = ^cmp_val_s;
`endif

    assign probe_dout   = probe_dout_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign timeout      = timeout_r;
    assign latency      = latency_r;
    assign mismatch_cnt = mismatch_cnt_r;

endmodule

// File: doc/latency_probe.md
Name: latency_probe

Overview:
- Stimulus/checker counterpart to the Delay line.
- Drives a known ramp into a pipeline under test (e.g. Delay) and receives the pipeline output.
- Measures the pipeline latency in clock cycles and counts corrupted samples.
- Used in bring-up and self-test of the readout datapath; result is held on status ports for register readback.

Parameters:
- WIDTH, 8, data width of stimulus and response.
- MAX_LATENCY, 64, largest latency searched before timeout; also sets flush length.
- NUM_SAMPLES, 255, ramp length; legal range 1..2**WIDTH-1.
- CNT_W, $clog2(MAX_LATENCY+1), width of LATENCY (derived localparam).

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a measurement when idle.
- PROBE_DOUT  out  WIDTH  stimulus to pipeline input (registered).
- PROBE_DIN  in  WIDTH  response from pipeline output.
- BUSY  out  1  high from the cycle after an accepted START until FINISH.
- DONE  out  1  one-cycle pulse in FINISH.
- TIMEOUT  out  1  sticky; no response within MAX_LATENCY cycles.
- LATENCY  out  CNT_W  measured latency; all-ones on timeout.
- MISMATCH_CNT  out  16  saturating count of wrong samples.

Behaviour:
- Reset: state IDLE; PROBE_DOUT=0, BUSY=0, DONE=0, TIMEOUT=0, LATENCY=0, MISMATCH_CNT=0; all counters cleared. Reset at any point, including mid-measurement, aborts with no DONE pulse.
- IDLE:
  - START=1 → FLUSH; on the same edge clear TIMEOUT, LATENCY and MISMATCH_CNT.
  - START while not IDLE is ignored.
- FLUSH:
  - Drive PROBE_DOUT=0 for exactly MAX_LATENCY+1 cycles; PROBE_DIN is ignored.
  - The last FLUSH edge loads PROBE_DOUT<=1 and enters SEND_WAIT with lat_cnt=0.
- Transmit side (independent of receive state):
  - In the k-th cycle after leaving FLUSH (k=0..NUM_SAMPLES-1), PROBE_DOUT=k+1.
  - After value NUM_SAMPLES, PROBE_DOUT=0 until the next run.
- SEND_WAIT:
  - Each cycle, if PROBE_DIN!=0: LATENCY<=lat_cnt, rx_idx<=1, expected<=2; compare the sample with 1 (a mismatch increments MISMATCH_CNT); → CHECK, or → FINISH if NUM_SAMPLES==1.
  - Else if lat_cnt==MAX_LATENCY: TIMEOUT<=1, LATENCY<=all-ones → FINISH.
  - Else lat_cnt<=lat_cnt+1.
  - Latency convention: a direct wire PROBE_DIN=PROBE_DOUT gives LATENCY=0; N register stages give N.
- CHECK:
  - Each cycle, compare PROBE_DIN with expected; a mismatch increments MISMATCH_CNT, saturating at 16'hFFFF.
  - expected<=expected+1 and rx_idx<=rx_idx+1.
  - When rx_idx==NUM_SAMPLES-1 on that compare → FINISH.
  - No resync on error: expected always advances.
- FINISH: DONE=1 for one cycle, BUSY=0 in that cycle → IDLE.
- BUSY: high in FLUSH, SEND_WAIT and CHECK.
- Results hold in IDLE until the next accepted START.
- Arithmetic: ramp and expected values are WIDTH bits. NUM_SAMPLES ≤ 2**WIDTH-1, so the ramp never wraps to 0; 0 is reserved as the "no data" marker.
- Simultaneous START and RESET: RESET wins.

Optional Feature:
- Macro LATENCY_PROBE_FIRST_ERR_EN.
- Defined: adds output FIRST_ERR_IDX [WIDTH-1:0] and flag FIRST_ERR_VALID.
  - Both are captured at the first mismatch of a run, as the ramp index 1..NUM_SAMPLES.
  - Both clear on reset and on an accepted START.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Loopback PROBE_DIN=PROBE_DOUT, defaults, one START → LATENCY=0, MISMATCH_CNT=0, TIMEOUT=0. DONE fires 65+255 cycles after the FLUSH entry edge.
- Through Delay (DELAY_CLK=10, WIDTH=8), defaults → LATENCY=10, MISMATCH_CNT=0, single DONE pulse, BUSY low afterwards.
- PROBE_DIN tied to 0 → TIMEOUT=1, LATENCY=7'h7F, MISMATCH_CNT=0. DONE occurs 65 cycles after SEND_WAIT entry.
- Loopback with PROBE_DIN forced to 8'h00 when the ramp value is 100, plus 8'h05 when it is 200 → MISMATCH_CNT=2, LATENCY=0. With LATENCY_PROBE_FIRST_ERR_EN: FIRST_ERR_IDX=100.
- Second START pulse during CHECK → ignored, results identical to the single-START run. RESET asserted mid-CHECK → next cycle all outputs at reset values, no DONE; a following START runs normally.
